md_sequencer: RTL

Multi-cycle multiply/divide controller for the execute stage. It accepts RV32M operations flagged by the decode/execute register (`de2ex_MD_OP_ffout`) and runs them on an iterative shift-add / restoring-divide datapath. While the operation runs it stalls the de2ex pipeline register. It then presents a 32-bit result and destination index for one cycle, which the execute stage muxes onto `ex2mem_wr_wdata`.

---
 rtl/md_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: iterative RV32M multiply/divide controller for the execute stage.
// Optional macro MD_FAST_MUL_EN: multiplies use a one-shot 33x33 product and skip CALC.
module md_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        de2ex_inst_valid_ffout,
  input  logic        de2ex_MD_OP_ffout,
  input  logic [2:0]  de2ex_aluop_ffout,
  input  logic [31:0] de2ex_rd_oprand1_ffout,
  input  logic [31:0] de2ex_rd_oprand2_ffout,
  input  logic [4:0]  de2ex_wr_regindex_ffout,
  input  logic        md_flush,
  output logic        md_stall,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] md_result,
  output logic [4:0]  md_wr_regindex
);

  // Handshake: req acts as valid from de2ex; md_stall is the inverse of ready and holds
  // de2ex until md_done, after which the pipeline advances at the end of that cycle.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic        neg_q, neg_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  wrrd_q, wrrd_d;

  logic        req, is_div, op1_sgn, op2_sgn, op1_neg, op2_neg, div_zero, start_fix;
  logic [31:0] op1, op2, mag1, mag2;

  assign op1      = de2ex_rd_oprand1_ffout;
  assign op2      = de2ex_rd_oprand2_ffout;
  assign req      = de2ex_inst_valid_ffout & de2ex_MD_OP_ffout & (state_q == IDLE);
  assign is_div   = de2ex_aluop_ffout[2];
  assign op1_sgn  = is_div ? ~de2ex_aluop_ffout[0] : (de2ex_aluop_ffout != 3'd3);
  assign op2_sgn  = is_div ? ~de2ex_aluop_ffout[0] : ~de2ex_aluop_ffout[1];
  assign op1_neg  = op1_sgn & op1[31];
  assign op2_neg  = op2_sgn & op2[31];
  assign mag1     = op1_neg ? (~op1 + 32'd1) : op1;
  assign mag2     = op2_neg ? (~op2 + 32'd1) : op2;
  assign div_zero = is_div & (op2 == 32'd0);

`ifdef MD_FAST_MUL_EN
  logic signed [32:0] fast_a, fast_b;
  logic signed [63:0] fast_p;
  assign fast_a    = {op1_neg, op1};
  assign fast_b    = {op2_neg, op2};
  assign fast_p    = 64'(fast_a) * 64'(fast_b);
  assign start_fix = div_zero | ~is_div;
`else
  assign start_fix = div_zero;
`endif

  // One iteration of shift-add multiply and restoring divide.
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [33:0] div_shift, div_diff;
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_step  = {mul_sum, acc_q[31:1]};
  assign div_shift = {rem_q, quo_q[31]};
  assign div_diff  = div_shift - {2'b00, opb_q};

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, res_sel;
  always_comb begin
    prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg_q ? (~quo_q + 32'd1) : quo_q;
    rem_fix  = neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    case (op_q)
      3'd0:       res_sel = prod_fix[31:0];
      3'd1, 3'd2,
      3'd3:       res_sel = prod_fix[63:32];
      3'd4, 3'd5: res_sel = quo_fix;
      default:    res_sel = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = start_fix ? FIX : CALC;
      CALC:    if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (md_flush) state_d = IDLE;
  end

  always_comb begin
    md_stall = req | (state_q == CALC) | (state_q == FIX);
    md_busy  = (state_q != IDLE);
    md_done  = (state_q == DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    rd_d   = rd_q;
    opb_d  = opb_q;
    acc_d  = acc_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    neg_d  = neg_q;
    res_d  = res_q;
    wrrd_d = wrrd_q;
    if (!md_flush) begin
      case (state_q)
        IDLE: if (req) begin
          op_d  = de2ex_aluop_ffout;
          rd_d  = de2ex_wr_regindex_ffout;
          cnt_d = 5'd0;
          if (div_zero) begin
            // Divide by zero: architected results, no sign fix.
            quo_d = 32'hFFFF_FFFF;
            rem_d = {1'b0, op1};
            neg_d = 1'b0;
          end else if (is_div) begin
            quo_d = mag1;
            rem_d = 33'd0;
            opb_d = mag2;
            neg_d = de2ex_aluop_ffout[1] ? op1_neg : (op1_neg ^ op2_neg);
          end else begin
`ifdef MD_FAST_MUL_EN
            acc_d = fast_p;
            neg_d = 1'b0;
`else
            acc_d = {32'd0, mag2};
            opb_d = mag1;
            neg_d = op1_neg ^ op2_neg;
`endif
          end
        end
        CALC: begin
          cnt_d = cnt_q + 5'd1;
          if (op_q[2]) begin
            rem_d = div_diff[33] ? div_shift[32:0] : div_diff[32:0];
            quo_d = {quo_q[30:0], ~div_diff[33]};
          end else begin
            acc_d = mul_step;
          end
        end
        FIX: begin
          res_d  = res_sel;
          wrrd_d = rd_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 5'd0;
      op_q   <= 3'd0;
      rd_q   <= 5'd0;
      opb_q  <= 32'd0;
      acc_q  <= 64'd0;
      rem_q  <= 33'd0;
      quo_q  <= 32'd0;
      neg_q  <= 1'b0;
      res_q  <= 32'd0;
      wrrd_q <= 5'd0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      rd_q   <= rd_d;
      opb_q  <= opb_d;
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      neg_q  <= neg_d;
      res_q  <= res_d;
      wrrd_q <= wrrd_d;
    end
  end

  assign md_result      = res_q;
  assign md_wr_regindex = wrrd_q;

endmodule
